// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution output collector and its
// per-lane requantizer.
package conv_pkg;

    localparam int PIXEL_W = 8;
    localparam int SUM_W   = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2
    } state_t;

    // Ceiling log2 with a one-bit floor so degenerate counters still exist.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) width++;
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/requant_sat.sv
// Per-lane requantization of a raw 32-bit tree sum: arithmetic right shift,
// ReLU, then clamp into the unsigned 8-bit pixel range.
module requant_sat
    import conv_pkg::*;
#(
    parameter int SHIFT = 2
) (
    input  logic signed [SUM_W-1:0]   sum,
    output logic        [PIXEL_W-1:0] pixel
);

    logic signed [SUM_W-1:0] shifted;
    logic                    overflow;

    assign shifted  = sum >>> SHIFT;
    assign overflow = |shifted[SUM_W-2:PIXEL_W];

    // Negative results clip to zero before the upper-range clamp is considered.
    always_comb begin
        pixel = shifted[PIXEL_W-1:0];
        if (shifted[SUM_W-1])
            pixel = '0;
        else if (overflow)
            pixel = '1;
    end

endmodule

// File: rtl/conv_output_collector.sv
// Collects raw per-tree convolution sums, discards windows that wrap a row
// edge, and emits requantized pixels with an end-of-frame pulse.
module conv_output_collector
    import conv_pkg::*;
#(
    parameter int NUM_TREES    = 2,
    parameter int IMG_WIDTH    = 6,
    parameter int IMG_HEIGHT   = 6,
    parameter int KERNEL_SIZE  = 4,
    parameter int FILL_LATENCY = 29,
    parameter int SHIFT        = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         frame_start,
    input  logic [SUM_W*NUM_TREES-1:0]   sum_vector_in,
    output logic [PIXEL_W*NUM_TREES-1:0] pixel_vector_out,
    output logic                         out_valid,
    output logic                         frame_done,
    output logic                         busy
);

    localparam int FILL_W = clog2(FILL_LATENCY);
    localparam int COL_W  = clog2(IMG_WIDTH);
    localparam int ROW_W  = clog2(IMG_HEIGHT);

    localparam logic [FILL_W-1:0] FILL_INIT = FILL_W'(FILL_LATENCY - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_WIDTH - 1);
    localparam logic [COL_W-1:0]  COL_EDGE  = COL_W'(IMG_WIDTH - KERNEL_SIZE);
    localparam logic [ROW_W-1:0]  ROW_EDGE  = ROW_W'(IMG_HEIGHT - KERNEL_SIZE);

    state_t                       state;
    state_t                       next_state;
    logic [FILL_W-1:0]            fill_cnt;
    logic [FILL_W-1:0]            fill_next;
    logic [COL_W-1:0]             col;
    logic [COL_W-1:0]             col_next;
    logic [ROW_W-1:0]             row;
    logic [ROW_W-1:0]             row_next;
    logic                         window_valid;
    logic                         last_window;
    logic [PIXEL_W*NUM_TREES-1:0] requant_bus;

    assign window_valid = (state == STREAM) && (col <= COL_EDGE) && (row <= ROW_EDGE);
    assign last_window  = (state == STREAM) && (col == COL_EDGE) && (row == ROW_EDGE);
    assign busy         = (state != IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            fill_cnt <= '0;
            col      <= '0;
            row      <= '0;
        end else begin
            state    <= next_state;
            fill_cnt <= fill_next;
            col      <= col_next;
            row      <= row_next;
        end
    end

    // A frame_start in any state restarts the fill wait from scratch.
    always_comb begin
        next_state = state;
        fill_next  = fill_cnt;
        col_next   = col;
        row_next   = row;
        if (frame_start) begin
            next_state = FILL;
            fill_next  = FILL_INIT;
            col_next   = '0;
            row_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    next_state = IDLE;
                end
                FILL: begin
                    if (fill_cnt == '0) begin
                        next_state = STREAM;
                        col_next   = '0;
                        row_next   = '0;
                    end else begin
                        fill_next = fill_cnt - FILL_W'(1);
                    end
                end
                STREAM: begin
                    if (last_window) begin
                        next_state = IDLE;
                        col_next   = '0;
                        row_next   = '0;
                    end else if (col == COL_LAST) begin
                        col_next = '0;
                        row_next = row + ROW_W'(1);
                    end else begin
                        col_next = col + COL_W'(1);
                    end
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

    for (genvar i = 0; i < NUM_TREES; i++) begin : g_lane
        requant_sat #(
            .SHIFT (SHIFT)
        ) u_requant (
            .sum   (sum_vector_in[SUM_W*i +: SUM_W]),
            .pixel (requant_bus[PIXEL_W*i +: PIXEL_W])
        );
    end

    // Pixels only update on real windows so the last valid result is held.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pixel_vector_out <= '0;
            out_valid        <= 1'b0;
            frame_done       <= 1'b0;
        end else begin
            out_valid  <= window_valid;
            frame_done <= window_valid && last_window && !frame_start;
            if (window_valid)
                pixel_vector_out <= requant_bus;
        end
    end

endmodule

// File: tb/tb_conv_output_collector.sv
// Bench for conv_output_collector: requant table frames, restart and reset
// sequences, and a randomized run against a frame-timeline reference model.
module tb_conv_output_collector;

    localparam int NUM_TREES       = 2;
    localparam int IMG_WIDTH       = 6;
    localparam int IMG_HEIGHT      = 6;
    localparam int KERNEL_SIZE     = 4;
    localparam int FILL_LATENCY    = 29;
    localparam int SHIFT           = 2;
    localparam int STREAM_LEN      = (IMG_HEIGHT - KERNEL_SIZE) * IMG_WIDTH + (IMG_WIDTH - KERNEL_SIZE) + 1;
    localparam int VALID_PER_FRAME = (IMG_WIDTH - KERNEL_SIZE + 1) * (IMG_HEIGHT - KERNEL_SIZE + 1);

    typedef struct packed {
        logic [31:0] sum1;
        logic [31:0] sum0;
        logic [7:0]  exp1;
        logic [7:0]  exp0;
    } vec_t;

    logic        clock;
    logic        reset;
    logic        frame_start;
    logic [63:0] sum_vector_in;
    logic [15:0] pixel_vector_out;
    logic        out_valid;
    logic        frame_done;
    logic        busy;

    int          checks;
    int          errors;
    int          cycle;
    bit          m_active;
    int          m_start;
    logic        exp_valid;
    logic        exp_done;
    logic        exp_busy;
    logic [15:0] exp_pix;
    vec_t        table_v[VALID_PER_FRAME];

    conv_output_collector #(
        .NUM_TREES    (NUM_TREES),
        .IMG_WIDTH    (IMG_WIDTH),
        .IMG_HEIGHT   (IMG_HEIGHT),
        .KERNEL_SIZE  (KERNEL_SIZE),
        .FILL_LATENCY (FILL_LATENCY),
        .SHIFT        (SHIFT)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .frame_start      (frame_start),
        .sum_vector_in    (sum_vector_in),
        .pixel_vector_out (pixel_vector_out),
        .out_valid        (out_valid),
        .frame_done       (frame_done),
        .busy             (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic bit window_ok(input int k);
        return ((k % IMG_WIDTH) <= IMG_WIDTH - KERNEL_SIZE) && ((k / IMG_WIDTH) <= IMG_HEIGHT - KERNEL_SIZE);
    endfunction

    // Divide-and-clamp view of the requantization, independent of bit slicing.
    function automatic logic [7:0] ref_requant(input logic [31:0] raw);
        longint v;
        longint q;
        v = longint'($signed(raw));
        if (v < 0) return 8'd0;
        q = v / (longint'(1) << SHIFT);
        if (q > 255) return 8'd255;
        return 8'(q);
    endfunction

    function automatic logic [31:0] rand_sum();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 1100));
            2:       return 32'(-int'($urandom_range(0, 60)));
            default: return 32'($urandom_range(1010, 1030));
        endcase
    endfunction

    task automatic model_reset();
        m_active  = 1'b0;
        m_start   = 0;
        exp_valid = 1'b0;
        exp_done  = 1'b0;
        exp_busy  = 1'b0;
        exp_pix   = '0;
    endtask

    // Position within a frame is derived purely from elapsed edges since its frame_start.
    task automatic model_advance(input logic fs, input logic [63:0] sums);
        int k;
        bit v;
        bit last;
        v    = 1'b0;
        last = 1'b0;
        if (m_active) begin
            k = cycle - m_start - (FILL_LATENCY + 1);
            if (k >= 0) begin
                v    = window_ok(k);
                last = (k == STREAM_LEN - 1);
            end
        end
        exp_valid = v;
        exp_done  = v && last && !fs;
        if (v) exp_pix = {ref_requant(sums[63:32]), ref_requant(sums[31:0])};
        if (last) m_active = 1'b0;
        if (fs) begin
            m_active = 1'b1;
            m_start  = cycle;
        end
        exp_busy = m_active;
    endtask

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cycle, actual, expected);
        end
    endtask

    task automatic check_against_model();
        check_output("out_valid", out_valid, exp_valid);
        check_output("frame_done", frame_done, exp_done);
        check_output("busy", busy, exp_busy);
        check_output("pixel_vector_out", pixel_vector_out, exp_pix);
    endtask

    task automatic apply_stimulus(input logic fs, input logic [63:0] sums);
        frame_start   = fs;
        sum_vector_in = sums;
        @(posedge clock);
        #1;
        cycle++;
        model_advance(fs, sums);
        check_against_model();
    endtask

    task automatic run_table_frame(input string tag);
        int          start;
        int          first_valid;
        int          done_at;
        int          pulses;
        int          dones;
        int          j;
        int          k;
        logic [14:0] pattern;
        logic [14:0] want_pattern;
        logic [63:0] sums;
        want_pattern = 15'b111000111000111;
        apply_stimulus(1'b1, {rand_sum(), rand_sum()});
        start       = cycle;
        first_valid = -1;
        done_at     = -1;
        pulses      = 0;
        dones       = 0;
        j           = 0;
        pattern     = '0;
        for (int s = 1; s <= FILL_LATENCY + STREAM_LEN; s++) begin
            k    = s - FILL_LATENCY - 1;
            sums = {rand_sum(), rand_sum()};
            if (k >= 0 && window_ok(k)) sums = {table_v[j].sum1, table_v[j].sum0};
            apply_stimulus(1'b0, sums);
            if (k >= 0 && window_ok(k)) begin
                check_output({tag, " table pixel"}, 64'(pixel_vector_out), 64'({table_v[j].exp1, table_v[j].exp0}));
                j++;
            end
            if (k >= 0) pattern[STREAM_LEN - 1 - k] = out_valid;
            if (out_valid) begin
                pulses++;
                if (first_valid < 0) first_valid = cycle - start;
            end
            if (frame_done) begin
                dones++;
                done_at = cycle - start;
            end
        end
        check_output({tag, " first valid latency"}, 64'(first_valid), 64'(FILL_LATENCY + 1));
        check_output({tag, " valid pulses"}, 64'(pulses), 64'(VALID_PER_FRAME));
        check_output({tag, " valid pattern"}, 64'(pattern), 64'(want_pattern));
        check_output({tag, " frame_done count"}, 64'(dones), 64'd1);
        check_output({tag, " frame_done timing"}, 64'(done_at), 64'(FILL_LATENCY + STREAM_LEN));
        check_output({tag, " busy at frame end"}, 64'(busy), 64'd0);
    endtask

    task automatic run_restart();
        int start2;
        int first_valid;
        int dones_first;
        for (int s = 0; s <= FILL_LATENCY + 10; s++) begin
            apply_stimulus(s == 0, {rand_sum(), rand_sum()});
        end
        dones_first = 0;
        apply_stimulus(1'b1, {rand_sum(), rand_sum()});
        start2      = cycle;
        first_valid = -1;
        for (int s = 1; s <= FILL_LATENCY + STREAM_LEN; s++) begin
            apply_stimulus(1'b0, {rand_sum(), rand_sum()});
            if (out_valid && first_valid < 0) first_valid = cycle - start2;
            if (frame_done && (cycle - start2) < FILL_LATENCY + STREAM_LEN) dones_first++;
        end
        check_output("restart latency", 64'(first_valid), 64'(FILL_LATENCY + 1));
        check_output("restart aborted frame_done", 64'(dones_first), 64'd0);
        check_output("restart final frame_done", 64'(frame_done), 64'd1);
    endtask

    task automatic run_reset_mid_stream();
        int stray_valid;
        for (int s = 0; s <= FILL_LATENCY + 5; s++) begin
            apply_stimulus(s == 0, {rand_sum(), rand_sum()});
        end
        #3;
        reset = 1'b0;
        #1;
        check_output("reset pixel", 64'(pixel_vector_out), 64'd0);
        check_output("reset out_valid", 64'(out_valid), 64'd0);
        check_output("reset frame_done", 64'(frame_done), 64'd0);
        check_output("reset busy", 64'(busy), 64'd0);
        model_reset();
        for (int s = 0; s < 3; s++) apply_stimulus(1'b0, {rand_sum(), rand_sum()});
        #2;
        reset = 1'b1;
        stray_valid = 0;
        for (int s = 0; s < 60; s++) begin
            apply_stimulus(1'b0, {rand_sum(), rand_sum()});
            if (out_valid) stray_valid++;
        end
        check_output("no output after reset", 64'(stray_valid), 64'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cycle  = 0;
        model_reset();

        table_v[0] = '{sum1: 32'd1084,       sum0: 32'd588,        exp1: 8'd255, exp0: 8'd147};
        table_v[1] = '{sum1: 32'd1188,       sum0: 32'd644,        exp1: 8'd255, exp0: 8'd161};
        table_v[2] = '{sum1: 32'hFFFF_FFFB,  sum0: 32'd3,          exp1: 8'd0,   exp0: 8'd0};
        table_v[3] = '{sum1: 32'd1023,       sum0: 32'd1024,       exp1: 8'd255, exp0: 8'd255};
        table_v[4] = '{sum1: 32'd1020,       sum0: 32'd1019,       exp1: 8'd255, exp0: 8'd254};
        table_v[5] = '{sum1: 32'd0,          sum0: 32'hFFFF_FFFF,  exp1: 8'd0,   exp0: 8'd0};
        table_v[6] = '{sum1: 32'd4,          sum0: 32'd7,          exp1: 8'd1,   exp0: 8'd1};
        table_v[7] = '{sum1: 32'h8000_0000,  sum0: 32'h7FFF_FFFF,  exp1: 8'd0,   exp0: 8'd255};
        table_v[8] = '{sum1: 32'd400,        sum0: 32'd100,        exp1: 8'd100, exp0: 8'd25};

        reset         = 1'b0;
        frame_start   = 1'b0;
        sum_vector_in = '0;
        repeat (2) @(posedge clock);
        #1;
        check_output("initial pixel", 64'(pixel_vector_out), 64'd0);
        check_output("initial out_valid", 64'(out_valid), 64'd0);
        check_output("initial frame_done", 64'(frame_done), 64'd0);
        check_output("initial busy", 64'(busy), 64'd0);
        #3;
        reset = 1'b1;

        run_table_frame("frame A");
        run_table_frame("frame B back-to-back");
        for (int s = 0; s < 5; s++) apply_stimulus(1'b0, {rand_sum(), rand_sum()});
        run_restart();
        run_reset_mid_stream();

        for (int s = 0; s < 1500; s++) begin
            apply_stimulus($urandom_range(0, 79) == 0, {rand_sum(), rand_sum()});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
